// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader: header byte, store depth,
// state encodings and the checksum accumulate helper.
package prog_loader_pkg;

   localparam logic [7:0] HDR_BYTE   = 8'hA5;
   localparam int         PROG_DEPTH = 16;
   localparam int         IDX_W      = $clog2(PROG_DEPTH);

   typedef enum logic [1:0] {
      WAIT_HDR = 2'd0,
      LOAD     = 2'd1,
      CHECK    = 2'd2,
      RUN      = 2'd3
   } ld_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 serial receiver: synchronised input, mid-bit sampling, one-cycle
// byte_valid / frame_err pulses.
module uart_rx
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

   logic        meta_q, sync_q, prev_q;
   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rxd;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Receiver state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RX_IDLE;
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // Bit timing and sampling; a false start drops back to idle-line search
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (prev_q && !sync_q) begin
               state_d = RX_START;
               cnt_d   = 16'd0;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = 16'd0;
               bit_d = 3'd0;
               if (!sync_q) begin
                  state_d = RX_DATA;
               end else begin
                  state_d = RX_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = 16'd0;
               shift_d = {sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = 16'd0;
               state_d = RX_IDLE;
               if (sync_q) begin
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   assign byte_data  = shift_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Serial boot loader: receives a header/16-byte/checksum frame into a 16x8
// program store and holds the CPU in reset until a frame verifies.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic [3:0] adr,
   output logic [7:0] dout,
   output logic       cpu_reset,
   output logic       busy,
   output logic       err
);

   logic [7:0]       rx_data_s;
   logic             rx_valid_s;
   logic             rx_ferr_s;
   logic             hdr_s;
   logic             mem_we_s;

   ld_state_e        state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic             cpu_reset_q, cpu_reset_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [7:0]       mem_q [PROG_DEPTH];

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .byte_data (rx_data_s),
      .byte_valid(rx_valid_s),
      .frame_err (rx_ferr_s)
   );

   assign hdr_s = rx_valid_s && (rx_data_s == HDR_BYTE);

   // Loader state, counters and registered control outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= WAIT_HDR;
         idx_q       <= '0;
         sum_q       <= 8'h00;
         cpu_reset_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   // Frame protocol: header starts a load; in LOAD/CHECK every byte is data
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      cpu_reset_d = cpu_reset_q;
      busy_d      = busy_q;
      err_d       = err_q;
      mem_we_s    = 1'b0;
      case (state_q)
         WAIT_HDR, RUN: begin
            if (hdr_s) begin
               state_d     = LOAD;
               idx_d       = '0;
               sum_d       = 8'h00;
               cpu_reset_d = 1'b0;
               busy_d      = 1'b1;
               err_d       = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         LOAD: begin
            if (rx_valid_s) begin
               mem_we_s = 1'b1;
               sum_d    = sum8(sum_q, rx_data_s);
               idx_d    = idx_q + 4'd1;
               if (idx_q == 4'(PROG_DEPTH - 1)) begin
                  state_d = CHECK;
               end else begin
                  state_d = LOAD;
               end
            end else if (rx_ferr_s) begin
               state_d     = WAIT_HDR;
               cpu_reset_d = 1'b0;
               busy_d      = 1'b0;
               err_d       = 1'b1;
            end else begin
               state_d = LOAD;
            end
         end
         CHECK: begin
            if (rx_valid_s) begin
               busy_d = 1'b0;
               if (rx_data_s == sum_q) begin
                  state_d     = RUN;
                  cpu_reset_d = 1'b1;
               end else begin
                  state_d     = WAIT_HDR;
                  cpu_reset_d = 1'b0;
                  err_d       = 1'b1;
               end
            end else if (rx_ferr_s) begin
               state_d     = WAIT_HDR;
               cpu_reset_d = 1'b0;
               busy_d      = 1'b0;
               err_d       = 1'b1;
            end else begin
               state_d = CHECK;
            end
         end
         default: begin
            state_d     = WAIT_HDR;
            cpu_reset_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // Program store; cleared on reset, written only while loading
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PROG_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (mem_we_s) begin
         mem_q[idx_q] <= rx_data_s;
      end
   end

   assign dout      = mem_q[adr];
   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: serial frames bit-banged on rxd, outputs and
// program store checked against hand-computed values.
module tb_prog_loader;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd;
   logic [3:0] adr;
   logic [7:0] dout;
   logic       cpu_reset;
   logic       busy;
   logic       err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] img [16];

   prog_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .reset    (reset),
      .rxd      (rxd),
      .adr      (adr),
      .dout     (dout),
      .cpu_reset(cpu_reset),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_hdr_img();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 16; i++) send_byte(img[i], 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      checks++;
      if ({cpu_reset, busy, err} !== 3'b000) begin
         failures++;
         $display("FAIL reset_outs: {cpu_reset,busy,err}=%b expected 000", {cpu_reset, busy, err});
      end
      for (int i = 0; i < 16; i++) begin
         adr = 4'(i);
         #1;
         checks++;
         if (dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_mem[%0d]: dout=%h expected 00", i, dout);
         end
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b000) begin
         failures++;
         $display("FAIL reset_release: {cpu_reset,busy,err}=%b expected 000", {cpu_reset, busy, err});
      end
   endtask

   task automatic test_good_load();
      for (int i = 0; i < 16; i++) img[i] = 8'(i);
      send_hdr_img();
      checks++;
      if ({cpu_reset, busy, err} !== 3'b010) begin
         failures++;
         $display("FAIL good_loading: {cpu_reset,busy,err}=%b expected 010", {cpu_reset, busy, err});
      end
      fork
         send_byte(8'h78, 1'b1);
         begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < CPB * 12 && !seen; i++) begin
               @(negedge clk);
               if (dut.rx_valid_s) seen = 1'b1;
            end
            checks++;
            if (!seen || cpu_reset !== 1'b0) begin
               failures++;
               $display("FAIL good_csum_valid: seen=%b cpu_reset=%b expected seen=1 cpu_reset=0", seen, cpu_reset);
            end
            @(negedge clk);
            checks++;
            if (cpu_reset !== 1'b1) begin
               failures++;
               $display("FAIL good_rise_timing: cpu_reset=%b expected 1", cpu_reset);
            end
         end
      join
      checks++;
      if ({cpu_reset, busy, err} !== 3'b100) begin
         failures++;
         $display("FAIL good_outs: {cpu_reset,busy,err}=%b expected 100", {cpu_reset, busy, err});
      end
      for (int i = 0; i < 16; i++) begin
         adr = 4'(i);
         #1;
         checks++;
         if (dout !== 8'(i)) begin
            failures++;
            $display("FAIL good_mem[%0d]: dout=%h expected %h", i, dout, 8'(i));
         end
      end
      adr = 4'h3;
      #1;
      checks++;
      if (dout !== 8'h03) begin
         failures++;
         $display("FAIL good_adr3: dout=%h expected 03", dout);
      end
   endtask

   task automatic test_bad_checksum();
      for (int i = 0; i < 16; i++) img[i] = 8'(i);
      send_hdr_img();
      send_byte(8'h77, 1'b1);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b001) begin
         failures++;
         $display("FAIL badsum_outs: {cpu_reset,busy,err}=%b expected 001", {cpu_reset, busy, err});
      end
      send_byte(8'h3C, 1'b1);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b001) begin
         failures++;
         $display("FAIL badsum_wait_hdr: {cpu_reset,busy,err}=%b expected 001", {cpu_reset, busy, err});
      end
      send_hdr_img();
      send_byte(8'h78, 1'b1);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b100) begin
         failures++;
         $display("FAIL badsum_recover: {cpu_reset,busy,err}=%b expected 100", {cpu_reset, busy, err});
      end
   endtask

   task automatic test_run_reload();
      send_byte(8'h3C, 1'b1);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b100) begin
         failures++;
         $display("FAIL run_ignore: {cpu_reset,busy,err}=%b expected 100", {cpu_reset, busy, err});
      end
      fork
         send_byte(8'hA5, 1'b1);
         begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < CPB * 12 && !seen; i++) begin
               @(negedge clk);
               if (dut.rx_valid_s) seen = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (!seen || cpu_reset !== 1'b0 || busy !== 1'b1) begin
               failures++;
               $display("FAIL run_hdr_drop: seen=%b cpu_reset=%b busy=%b expected 1 0 1", seen, cpu_reset, busy);
            end
         end
      join
      img[0] = 8'hA5;
      for (int i = 1; i < 16; i++) img[i] = 8'(i);
      for (int i = 0; i < 16; i++) send_byte(img[i], 1'b1);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b010) begin
         failures++;
         $display("FAIL a5_data_busy: {cpu_reset,busy,err}=%b expected 010", {cpu_reset, busy, err});
      end
      send_byte(8'h1D, 1'b1);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b100) begin
         failures++;
         $display("FAIL a5_data_csum: {cpu_reset,busy,err}=%b expected 100", {cpu_reset, busy, err});
      end
      for (int i = 0; i < 16; i++) begin
         adr = 4'(i);
         #1;
         checks++;
         if (dout !== img[i]) begin
            failures++;
            $display("FAIL a5_data_mem[%0d]: dout=%h expected %h", i, dout, img[i]);
         end
      end
   endtask

   task automatic test_frame_err();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
      send_byte(8'h55, 1'b0);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b001) begin
         failures++;
         $display("FAIL ferr_outs: {cpu_reset,busy,err}=%b expected 001", {cpu_reset, busy, err});
      end
      for (int i = 0; i < 16; i++) begin
         logic [7:0] e;
         e = (i < 4) ? 8'h10 + 8'(i) : 8'(i);
         adr = 4'(i);
         #1;
         checks++;
         if (dout !== e) begin
            failures++;
            $display("FAIL ferr_mem[%0d]: dout=%h expected %h", i, dout, e);
         end
      end
      send_byte(8'h42, 1'b0);
      checks++;
      if ({cpu_reset, busy, err} !== 3'b001) begin
         failures++;
         $display("FAIL ferr_idle_ignored: {cpu_reset,busy,err}=%b expected 001", {cpu_reset, busy, err});
      end
   endtask

   task automatic test_glitch();
      int events;
      events = 0;
      fork
         begin
            rxd = 1'b0;
            repeat (5) @(negedge clk);
            rxd = 1'b1;
            repeat (3 * CPB) @(negedge clk);
         end
         begin
            for (int i = 0; i < 3 * CPB + 4; i++) begin
               @(negedge clk);
               if (dut.rx_valid_s || dut.rx_ferr_s) events++;
            end
         end
      join
      checks++;
      if (events !== 0) begin
         failures++;
         $display("FAIL glitch_events: rx events=%0d expected 0", events);
      end
      checks++;
      if ({cpu_reset, busy, err} !== 3'b001) begin
         failures++;
         $display("FAIL glitch_outs: {cpu_reset,busy,err}=%b expected 001", {cpu_reset, busy, err});
      end
   endtask

   task automatic test_reset_mid_load();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 9; i++) send_byte(8'h20 + 8'(i), 1'b1);
      rxd = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      reset = 1'b0;
      rxd = 1'b1;
      #1;
      checks++;
      if ({cpu_reset, busy, err} !== 3'b000) begin
         failures++;
         $display("FAIL midreset_outs: {cpu_reset,busy,err}=%b expected 000", {cpu_reset, busy, err});
      end
      for (int i = 0; i < 16; i++) begin
         adr = 4'(i);
         #1;
         checks++;
         if (dout !== 8'h00) begin
            failures++;
            $display("FAIL midreset_mem[%0d]: dout=%h expected 00", i, dout);
         end
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      test_good_load();
   endtask

   initial begin
      reset = 1'b0;
      rxd   = 1'b1;
      adr   = 4'h0;
      repeat (2) @(negedge clk);
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_run_reload();
      test_frame_err();
      test_glitch();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
